// File: rtl/level_sensor_conditioner_pkg.sv
// Shared definitions for the reservoir level front end and the flow controller.
//   LVL_0..LVL_3    : the only legal thermometer codes on s[3:1]
//   valid_state_e   : states of the code-validity FSM
//   is_legal()      : 1 when a 3-bit code is one of the four level codes
//   level_index()   : maps a legal code to its level 0..3 (illegal codes map to 0)
package level_sensor_conditioner_pkg;

    localparam logic [2:0] LVL_0 = 3'b000;
    localparam logic [2:0] LVL_1 = 3'b001;
    localparam logic [2:0] LVL_2 = 3'b011;
    localparam logic [2:0] LVL_3 = 3'b111;

    typedef enum logic [1:0] {
        StOk      = 2'd0,
        StSuspect = 2'd1,
        StFault   = 2'd2
    } valid_state_e;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == LVL_0) || (code == LVL_1) || (code == LVL_2) || (code == LVL_3);
    endfunction

    function automatic logic [1:0] level_index(input logic [2:0] code);
        logic [1:0] idx;
        case (code)
            LVL_1:   idx = 2'd1;
            LVL_2:   idx = 2'd2;
            LVL_3:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sensor_debounce_bit.sv
// Two-flop synchroniser followed by a debounce counter for one float switch.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   raw     : raw switch input, asynchronous to clk
//   stable  : debounced level; follows raw only after DB_CYCLES consecutive
//             synchronised samples disagree with the current stable value
module sensor_debounce_bit #(
    parameter int unsigned DB_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
                // Any agreeing sample restarts the qualification window.
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
                // This edge is the DB_CYCLES-th mismatching sample.
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/level_sensor_conditioner.sv
// Conditions the three reservoir float switches into a clean level code.
//   clk           : system clock
//   reset_n       : asynchronous active-low reset
//   raw_s[3:1]    : raw float switches (bit n = water above sensor n)
//   fault_clr     : request to clear a sticky sensor fault
//   s[3:1]        : registered level code, always one of LVL_0..LVL_3
//   sensor_fault  : sticky flag, an illegal code persisted FAULT_CYCLES cycles
//   level_changed : one-cycle pulse on the cycle s takes a new value
//   jump_event    : one-cycle pulse when that change skips at least one level
module level_sensor_conditioner
    import level_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES    = 8,
    parameter int unsigned FAULT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:1] raw_s,
    input  logic       fault_clr,
    output logic [3:1] s,
    output logic       sensor_fault,
    output logic       level_changed,
    output logic       jump_event
);

    localparam int unsigned FcW = $clog2(FAULT_CYCLES + 1);

    logic [3:1]     stable;
    valid_state_e   state_q;
    logic [FcW-1:0] fault_cnt_q;

    for (genvar i = 1; i <= 3; i++) begin : g_bit
        sensor_debounce_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (raw_s[i]),
            .stable (stable[i])
        );
    end

    logic       code_legal;
    logic       code_new;
    logic       big_step;
    logic [1:0] idx_new;
    logic [1:0] idx_old;

    always_comb begin
        code_legal = is_legal(stable);
        code_new   = (stable != s);
        idx_new    = level_index(stable);
        idx_old    = level_index(s);
        big_step   = (idx_new > idx_old) ? ((idx_new - idx_old) > 2'd1)
                                         : ((idx_old - idx_new) > 2'd1);
    end

    // Validity FSM. s is only ever loaded from a legal debounced code, so it
    // holds the last legal level while the sensors look broken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StOk;
            fault_cnt_q   <= '0;
            s             <= LVL_0;
            sensor_fault  <= 1'b0;
            level_changed <= 1'b0;
            jump_event    <= 1'b0;
        end else begin
            level_changed <= 1'b0;
            jump_event    <= 1'b0;
            unique case (state_q)
                StOk: begin
                    if (code_legal) begin
                        s             <= stable;
                        level_changed <= code_new;
                        jump_event    <= code_new && big_step;
                    end else begin
                        fault_cnt_q <= FcW'(1);
                        if (FAULT_CYCLES == 1) begin
                            state_q      <= StFault;
                            sensor_fault <= 1'b1;
                        end else begin
                            state_q <= StSuspect;
                        end
                    end
                end
                StSuspect: begin
                    if (code_legal) begin
                        state_q       <= StOk;
                        fault_cnt_q   <= '0;
                        s             <= stable;
                        level_changed <= code_new;
                        jump_event    <= code_new && big_step;
                    end else begin
                        fault_cnt_q <= fault_cnt_q + 1'b1;
                        if (fault_cnt_q == FcW'(FAULT_CYCLES - 1)) begin
                            state_q      <= StFault;
                            sensor_fault <= 1'b1;
                        end
                    end
                end
                StFault: begin
                    // Clearing needs both the request and a legal code together.
                    if (fault_clr && code_legal) begin
                        state_q       <= StOk;
                        fault_cnt_q   <= '0;
                        sensor_fault  <= 1'b0;
                        s             <= stable;
                        level_changed <= code_new;
                        jump_event    <= code_new && big_step;
                    end
                end
                default: begin
                    state_q <= StOk;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Scoreboard bench for level_sensor_conditioner: directed scenarios followed by
// randomized switch activity, checked against a behavioural model.
module tb_level_sensor_conditioner;
    import level_sensor_conditioner_pkg::*;

    localparam int unsigned DB_CYCLES    = 8;
    localparam int unsigned FAULT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:1] raw_s;
    logic       fault_clr;
    logic [3:1] s;
    logic       sensor_fault;
    logic       level_changed;
    logic       jump_event;

    level_sensor_conditioner #(
        .DB_CYCLES   (DB_CYCLES),
        .FAULT_CYCLES(FAULT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_s        (raw_s),
        .fault_clr    (fault_clr),
        .s            (s),
        .sensor_fault (sensor_fault),
        .level_changed(level_changed),
        .jump_event   (jump_event)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] s;
        logic       fault;
        logic       lc;
        logic       je;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_lc;
    int   n_je;

    // Behavioural model state.
    logic [2:0] hist[$];   // raw values sampled at each clock edge, oldest first
    logic [2:0] m_stable;  // debounced code
    logic [2:0] m_s;
    logic       m_fault;
    int         m_run;     // consecutive illegal cycles seen by the validity check

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DB_CYCLES + 2; i++) hist.push_back(3'b000);
        m_stable = 3'b000;
        m_s      = 3'b000;
        m_fault  = 1'b0;
        m_run    = 0;
    endtask

    // Advance the model by one clock edge at which raw r and clear clr were sampled.
    task automatic model_edge(input logic [2:0] r, input logic clr);
        logic [2:0] c;
        logic       legal, take, lc, je, all_new;
        int         d;
        c     = m_stable;
        legal = (c == 3'b000) || (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
        take  = 1'b0;
        lc    = 1'b0;
        je    = 1'b0;
        if (m_fault) begin
            if (clr && legal) begin
                m_fault = 1'b0;
                m_run   = 0;
                take    = 1'b1;
            end
        end else if (legal) begin
            m_run = 0;
            take  = 1'b1;
        end else begin
            m_run++;
            if (m_run >= FAULT_CYCLES) m_fault = 1'b1;
        end
        if (take) begin
            if (c != m_s) begin
                lc = 1'b1;
                d  = $countones(c) - $countones(m_s);
                je = (d > 1) || (d < -1);
            end
            m_s = c;
        end
        // A bit follows the switch once the DB_CYCLES samples the debouncer has
        // seen (two edges behind the raw input) all show the opposite level.
        hist.push_back(r);
        for (int b = 0; b < 3; b++) begin
            all_new = 1'b1;
            for (int j = 0; j < DB_CYCLES; j++) begin
                if (hist[DB_CYCLES - j][b] == m_stable[b]) all_new = 1'b0;
            end
            if (all_new) m_stable[b] = ~m_stable[b];
        end
        void'(hist.pop_front());
        exp_q.push_back({m_s, m_fault, lc, je});
    endtask

    // Drive inputs between edges, model the next edge, return 1 time unit after it.
    task automatic step(input logic [2:0] r, input logic clr);
        raw_s     = r;
        fault_clr = clr;
        @(posedge clk);
        model_edge(r, clr);
        #1;
        if (level_changed) n_lc++;
        if (jump_event) n_je++;
    endtask

    task automatic hold(input logic [2:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b0);
    endtask

    // Asserts reset between edges and checks outputs clear without a clock edge.
    task automatic do_reset(input string name);
        #1;
        reset_n = 1'b0;
        #1;
        check({name, "_s"}, int'(s), 0);
        check({name, "_fault"}, int'(sensor_fault), 0);
        check({name, "_pulses"}, int'({level_changed, jump_event}), 0);
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: compare every post-edge output against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({s, sensor_fault, level_changed, jump_event} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got s=%b fault=%b lc=%b je=%b, expected s=%b fault=%b lc=%b je=%b",
                             $time, s, sensor_fault, level_changed, jump_event,
                             e.s, e.fault, e.lc, e.je);
                end
            end
        end
    end

    initial begin
        int found;
        logic [2:0] code;
        int len;

        reset_n   = 1'b0;
        raw_s     = 3'b000;
        fault_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_s", int'(s), 0);
        check("reset_flags", int'({sensor_fault, level_changed, jump_event}), 0);
        reset_n = 1'b1;
        hold(3'b000, 5);

        // Clean rise: s follows DB_CYCLES+3 edges after the first sampling edge.
        n_lc  = 0;
        n_je  = 0;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            step(3'b001, 1'b0);
            if (found == 0 && s == 3'b001) found = i;
        end
        check("clean_rise_latency", found, DB_CYCLES + 3);
        check("clean_rise_changed", n_lc, 1);
        check("clean_rise_jump", n_je, 0);

        // Glitches of 5 and 7 cycles rejected, 8 accepted.
        n_lc = 0;
        hold(3'b011, 5);
        hold(3'b001, 14);
        hold(3'b011, 7);
        hold(3'b001, 14);
        check("glitch_reject_s", int'(s), 1);
        check("glitch_reject_pulses", n_lc, 0);
        hold(3'b011, 8);
        hold(3'b001, 14);
        check("hold8_accepted_pulses", n_lc, 2);
        hold(3'b011, 20);
        check("level2_s", int'(s), 3);

        // Asynchronous reset mid-cycle with s = 011.
        do_reset("async_reset");
        hold(3'b000, 12);
        check("post_reset_s", int'(s), 0);

        // Sticky fault from 001 with illegal 101.
        hold(3'b001, 15);
        found = 0;
        for (int i = 1; i <= 40; i++) begin
            step(3'b101, 1'b0);
            if (found == 0 && sensor_fault) found = i;
        end
        check("fault_rise_edge", found, DB_CYCLES + 2 + FAULT_CYCLES);
        check("fault_hold_s", int'(s), 1);
        step(3'b101, 1'b1);
        check("clr_with_illegal_ignored", int'(sensor_fault), 1);
        hold(3'b011, 20);
        check("fault_sticky_on_legal", int'(sensor_fault), 1);
        n_lc = 0;
        step(3'b011, 1'b1);
        check("fault_clear", int'(sensor_fault), 0);
        check("fault_clear_s", int'(s), 3);
        check("fault_clear_changed", n_lc, 1);

        // Staggered 001 -> 111, bit 2 first then bit 3 first.
        hold(3'b001, 15);
        n_je = 0;
        hold(3'b011, 3);
        hold(3'b111, 20);
        check("stagger_s", int'(s), 7);
        check("stagger_no_jump", n_je, 0);
        hold(3'b001, 15);
        hold(3'b101, 3);
        hold(3'b111, 20);
        check("stagger_rev_no_fault", int'(sensor_fault), 0);

        // Simultaneous 000 -> 111 jump.
        hold(3'b000, 15);
        n_lc = 0;
        n_je = 0;
        hold(3'b111, 15);
        check("jump_s", int'(s), 7);
        check("jump_changed", n_lc, 1);
        check("jump_event", n_je, 1);

        // Randomized switch activity.
        for (int k = 0; k < 200; k++) begin
            if (k == 100) do_reset("random_reset");
            if ($urandom_range(0, 3) == 0) begin
                code = 3'($urandom_range(0, 7));
            end else begin
                case ($urandom_range(0, 3))
                    0:       code = LVL_0;
                    1:       code = LVL_1;
                    2:       code = LVL_2;
                    default: code = LVL_3;
                endcase
            end
            len = $urandom_range(1, 24);
            for (int j = 0; j < len; j++) step(code, ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/level_sensor_conditioner.md
Name: level_sensor_conditioner

Overview:
Upstream front end of the reservoir flow-control FSM. Takes three raw float-switch inputs, synchronises and debounces each one, and checks that the result is a legal thermometer level code. It then delivers a clean, registered s[3:1] to the controller. It flags implausible sensor states and level jumps so the controller never acts on bounce or on broken-sensor combinations.

Parameters:
DB_CYCLES, 8, consecutive stable synchronised cycles required before a sensor bit changes; legal range 1..255.
FAULT_CYCLES, 16, consecutive illegal debounced cycles before a sticky fault; legal range 1..255.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
raw_s  input  3 [3:1]  raw float switches, asynchronous to clk; bit n = water above sensor n
fault_clr  input  1  synchronous request to clear a sticky fault
s  output  3 [3:1]  conditioned level code to the flow controller
sensor_fault  output  1  sticky: illegal code persisted FAULT_CYCLES cycles
level_changed  output  1  one-cycle pulse whenever s changes
jump_event  output  1  one-cycle pulse when s changes by more than one level step

Behaviour:
- Reset (async assert, sync release):
  - s=000 and sensor_fault=0; level_changed=0 and jump_event=0.
  - Sync flops, debounced bits and counters all 0.
  - Validity FSM = OK.
  - Reset mid-operation discards all pending counts.
- Synchroniser: two flops per bit; sync2 is the synchronised value.
- Debounce, per bit, independently:
  - Counter width = clog2(DB_CYCLES+1).
  - If sync2 == stable bit, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DB_CYCLES, the stable bit takes sync2 on that edge and the counter clears.
  - A bounce that returns before DB_CYCLES mismatching cycles causes no change.
- Legal level codes (stable[3:1]): 000, 001, 011, 111. All other codes are illegal.
- Validity FSM states: OK, SUSPECT, FAULT.
  - OK: legal code → s <= stable. Illegal code → SUSPECT with fault counter = 1.
  - SUSPECT: s holds its last legal value. Legal code → OK, counter cleared, s <= stable. Illegal code → counter increments; when the counter reaches FAULT_CYCLES, go to FAULT and set sensor_fault=1.
  - FAULT: s holds its last legal value. Leave only when fault_clr=1 and the code is legal in the same cycle; then → OK, sensor_fault=0, s <= stable. fault_clr with an illegal code is ignored. A code returning to legal without fault_clr does not clear the fault.
- Latency: a clean raw transition held steady appears on s exactly DB_CYCLES+3 clk edges after the first sampling edge (2 sync + DB_CYCLES debounce + 1 output register). Default = 11.
- Level steps:
  - level index is 0..3 for 000/001/011/111.
  - level_changed pulses in the same cycle s takes a new value.
  - jump_event pulses in that same cycle if |new index − old index| > 1.
- Simultaneous multi-bit changes: bits debounce independently. Transient illegal intermediate codes shorter than FAULT_CYCLES only pass through SUSPECT and do not fault.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package: legal level code constants (LVL_0=000, LVL_1=001, LVL_2=011, LVL_3=111), the validity FSM state enum, and a code-to-index function. The flow controller reuses the level constants.
- One natural sub-module, sensor_debounce_bit (synchroniser + debounce counter, parameter DB_CYCLES), instantiated three times.
- Validity FSM and output logic stay in the top module.

Test Plan:
- Reset: drive reset_n low asynchronously mid-cycle while s=011 → s=000 and sensor_fault=0 immediately, without waiting for a clk edge; after release, s stays 000 with raw_s=000.
- Clean rise: raw_s 000→001 held → s=001 exactly 11 edges later; level_changed high for one cycle; jump_event=0.
- Glitch rejection: raw_s=001 and raw_s[2] high for 5 cycles, then low → s remains 001 and no pulses. A 7-cycle glitch is also rejected; an 8-cycle hold is accepted (s=011).
- Sticky fault:
  - With s=001, hold raw_s=101 → sensor_fault rises FAULT_CYCLES=16 cycles after the debounced code goes illegal; s holds 001 throughout.
  - Restore raw_s=011 → fault stays 1.
  - Pulse fault_clr → sensor_fault=0 and s=011 on that edge, with level_changed pulsed.
- Transient illegal: raw_s 001→111 with raw_s[2] edge 3 cycles before raw_s[3] → brief SUSPECT, no fault, s goes 001→011→111 or directly to 111 per debounce timing; no jump_event.
- Jump: raw_s 000→111 with all bits simultaneous → s=111 after 11 edges; level_changed and jump_event both pulse once.
